// File: rtl/fp_pkg.sv
// Package for the pipelined floating-point adder.
// Contents:
//   - Default exponent and mantissa widths.
//   - Derived bias and all-ones exponent constants.
//   - The canonical quiet NaN.
//   - The unpacked operand struct {sign, exp, man}.
//   - The special-class enum {NORMAL, ZERO, INF, NAN}.
// The constants and the struct are built for the default widths. Parametrised
// logic derives its own constants from EXP_W/MAN_W.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int W_DEF     = 1 + EXP_W_DEF + MAN_W_DEF;

  localparam int                   FP_BIAS     = (1 << (EXP_W_DEF - 1)) - 1;
  localparam logic [EXP_W_DEF-1:0] FP_EXP_ONES = '1;
  localparam logic [W_DEF-1:0]     FP_QNAN     =
    {1'b0, FP_EXP_ONES, 1'b1, {(MAN_W_DEF-1){1'b0}}};

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } fp_t;

  // Result class decided in S1. Only CLS_NORMAL goes through the arithmetic
  // path. The other classes are packed directly in S3.
  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter.
// Purely combinational. It counts zeros from the MSB of value down to the
// first set bit. An all-zero input returns W.
// Ports:
//   value  in   W             vector to scan
//   count  out  clog2(W+1)    number of leading zeros
module fp_lzc #(
  parameter int W = 27
) (
  input  logic [W-1:0]           value,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W + 1);

  // Scan from the LSB upwards so that the last hit wins. That hit is the
  // most significant set bit.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined floating-point adder/subtractor.
// Pipeline stages:
//   S1  align
//   S2  add
//   S3  normalise / round to nearest even / pack
// Uses a valid/ready handshake. When the output is stalled, the whole
// pipeline freezes.
// Denormals are flushed to zero. Special cases are resolved in S1.
// Optional build macro FP_ADD_FLAGS_EN adds the flags output
//   {invalid, overflow, underflow, inexact}.
// Ports:
//   clk        in   1  clock
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  operand pair valid
//   in_ready   out  1  operands accepted this cycle
//   a, b       in   W  operands
//   op_sub     in   1  1: a-b, 0: a+b
//   out_valid  out  1  result valid
//   out_ready  in   1  downstream accepts result
//   result     out  W  packed sum
//   flags      out  4  (FP_ADD_FLAGS_EN only) exception flags for result
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result
`ifdef FP_ADD_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int F   = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
  localparam int LZW = $clog2(F + 1);
  localparam int EW  = EXP_W + 2;          // room for carry and negative exponents

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Handshake: a single stall freezes every stage, so bubbles are preserved.
  // ---------------------------------------------------------------------------
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------------------------------------------------------------------
  // S1: unpack, classify, order by magnitude, align
  // ---------------------------------------------------------------------------
  logic             a_s, b_raw_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;

  assign {a_s, a_e, a_m}     = a;
  assign {b_raw_s, b_e, b_m} = b;
  assign b_s                 = b_raw_s ^ op_sub;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
  assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
  assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
  assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);

  // Magnitude compare on {exp,man}. A flushed denormal counts as exactly
  // zero, so it can never be chosen as the larger operand.
  logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
  logic                   swap;
  assign a_mag = a_zero ? '0 : {a_e, a_m};
  assign b_mag = b_zero ? '0 : {b_e, b_m};
  assign swap  = (b_mag > a_mag);

  logic             big_s, sm_zero;
  logic [EXP_W-1:0] big_e, sm_e, diff;
  logic [MAN_W-1:0] big_m, sm_m;
  logic [F-1:0]     big_ext, sm_ext, sm_shift, sm_lost, sm_align;
  logic [LZW-1:0]   shamt;

  assign big_s   = swap ? b_s : a_s;
  assign big_e   = swap ? b_e : a_e;
  assign big_m   = swap ? b_m : a_m;
  assign sm_e    = swap ? a_e : b_e;
  assign sm_m    = swap ? a_m : b_m;
  assign sm_zero = swap ? a_zero : b_zero;

  assign big_ext = {1'b1, big_m, 3'b000};
  assign sm_ext  = sm_zero ? '0 : {1'b1, sm_m, 3'b000};
  assign diff    = big_e - sm_e;
  // A shift of F or more pushes every bit into the sticky bit.
  assign shamt   = (int'(diff) >= F) ? LZW'(F) : LZW'(diff);
  assign {sm_shift, sm_lost} = {sm_ext, {F{1'b0}}} >> shamt;
  assign sm_align = sm_shift | {{(F-1){1'b0}}, |sm_lost};

  fp_class_e cls_n;
  logic      sign_n;

  // NOTE: every combinational output gets a default before any branch.
  // Without the defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    cls_n  = CLS_NORMAL;
    sign_n = big_s;
    if (a_nan || b_nan) begin
      cls_n = CLS_NAN;
    end else if (a_inf && b_inf) begin
      cls_n  = (a_s != b_s) ? CLS_NAN : CLS_INF;
      sign_n = a_s;
    end else if (a_inf) begin
      cls_n  = CLS_INF;
      sign_n = a_s;
    end else if (b_inf) begin
      cls_n  = CLS_INF;
      sign_n = b_s;
    end else if (a_zero && b_zero) begin
      cls_n  = CLS_ZERO;
      sign_n = a_s & b_s;          // -0 only when both are -0
    end
  end

  logic             s1_valid, s1_sign, s1_eff_sub;
  fp_class_e        s1_cls;
  logic [EXP_W-1:0] s1_exp;
  logic [F-1:0]     s1_big, s1_small;

  // ---------------------------------------------------------------------------
  // S2: magnitude add/subtract (s1_big >= s1_small always holds)
  // ---------------------------------------------------------------------------
  logic [F:0] sum_n;
  assign sum_n = s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                            : ({1'b0, s1_big} + {1'b0, s1_small});

  logic             s2_valid, s2_sign;
  fp_class_e        s2_cls;
  logic [EXP_W-1:0] s2_exp;
  logic [F:0]       s2_sum;

  // ---------------------------------------------------------------------------
  // S3: normalise, round to nearest even, pack
  // ---------------------------------------------------------------------------
  logic           carry, zero_sum;
  logic [LZW-1:0] lz;
  logic [F-1:0]   norm_m;
  logic [EW-1:0]  norm_e, fin_e;

  assign carry    = s2_sum[F];
  assign zero_sum = (s2_sum == '0);

  fp_lzc #(.W(F)) u_lzc (
    .value (s2_sum[F-1:0]),
    .count (lz)
  );

  always_comb begin
    if (carry) begin
      // The bit shifted out on a carry is folded into sticky.
      norm_m = {s2_sum[F:2], s2_sum[1] | s2_sum[0]};
      norm_e = EW'(s2_exp) + EW'(1);
    end else begin
      norm_m = s2_sum[F-1:0] << lz;
      norm_e = EW'(s2_exp) - EW'(lz);
    end
  end

  logic             g, r, st, rnd_up, mant_ovf, underflow, overflow;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] fin_m;

  assign g        = norm_m[2];
  assign r        = norm_m[1];
  assign st       = norm_m[0];
  assign rnd_up   = g & (r | st | norm_m[3]);
  assign mant_r   = {1'b0, norm_m[F-1:3]} + (MAN_W+2)'(rnd_up);
  assign mant_ovf = mant_r[MAN_W+1];
  assign fin_e    = norm_e + EW'(mant_ovf);
  assign fin_m    = mant_ovf ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

  // The MSB of norm_e set means the exponent went negative.
  assign underflow = norm_e[EW-1] || (norm_e == '0);
  assign overflow  = !underflow && (fin_e >= EW'(EXP_ONES));

  logic [W-1:0] packed_n;
  always_comb begin
    packed_n = '0;
    case (s2_cls)
      CLS_NAN:  packed_n = QNAN;
      CLS_INF:  packed_n = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      CLS_ZERO: packed_n = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (zero_sum)       packed_n = '0;   // exact cancellation gives +0
        else if (underflow) packed_n = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
        else if (overflow)  packed_n = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        else                packed_n = {s2_sign, fin_e[EXP_W-1:0], fin_m};
      end
    endcase
  end

`ifdef FP_ADD_FLAGS_EN
  // invalid is raised for any NaN result. Arithmetic exceptions only come
  // from the normal path.
  logic [3:0] flags_n;
  always_comb begin
    flags_n = '0;
    if (s2_cls == CLS_NAN) begin
      flags_n[3] = 1'b1;
    end else if (s2_cls == CLS_NORMAL && !zero_sum) begin
      flags_n[2] = overflow;
      flags_n[1] = underflow;
      flags_n[0] = g | r | st | overflow | underflow;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control registers: valid bits and the visible outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every stage then
  // samples the pre-edge value of the stage before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
`ifdef FP_ADD_FLAGS_EN
      flags     <= '0;
`endif
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      result    <= packed_n;
`ifdef FP_ADD_FLAGS_EN
      flags     <= flags_n;
`endif
    end
  end

  // NOTE: the datapath registers have no reset. Their contents are only
  // observed when the matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_cls     <= cls_n;
      s1_sign    <= sign_n;
      s1_eff_sub <= a_s ^ b_s;
      s1_exp     <= big_e;
      s1_big     <= big_ext;
      s1_small   <= sm_align;
      s2_cls     <= s1_cls;
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_sum     <= sum_n;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe.
// Stimulus:
//   - A table of {operands, expected} records is driven back-to-back.
//   - Hand-written sequences cover latency, backpressure and mid-flight reset.
// Expected values are pushed to a scoreboard queue on input transfer. They are
// popped and compared on output transfer.
module tb_fp_add_pipe;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, result;
`ifdef FP_ADD_FLAGS_EN
  logic [3:0]  flags;
`endif

  fp_add_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef FP_ADD_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    fp_t   a;
    fp_t   b;
    logic  sub;
    fp_t   exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] cur_exp, held, e_pop;
  int          n_checks = 0, n_errors = 0, n_out = 0, cyc = 0, last_lat = 0, t_pop, base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor, sampled mid-cycle. A transfer happens at the
  // following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", {31'b0, out_valid}, 32'd0);
        end else begin
          e_pop    = exp_q.pop_front();
          t_pop    = acc_q.pop_front();
          last_lat = cyc - t_pop;
          n_out++;
          check($sformatf("result#%0d", n_out), result, e_pop);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_q.push_back(cyc);
      end
    end
  end

  // Present one operand pair and hold it until it is accepted. The task
  // returns just after the accepting edge.
  task automatic drive(input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic sub_i, input logic [31:0] exp_i);
    int waited = 0;
    a = a_i; b = b_i; op_sub = sub_i; cur_exp = exp_i; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] bp_a[5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  logic [31:0] bp_e[5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

  initial begin
    vecs.push_back('{"3+-1.5",     32'h40400000, 32'hBFC00000, 1'b0, 32'h3FC00000});
    vecs.push_back('{"1-1",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000});
    vecs.push_back('{"tie_even",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000});
    vecs.push_back('{"round_up",   32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001});
    vecs.push_back('{"inf-inf",    32'h7F800000, 32'hFF800000, 1'b0, FP_QNAN});
    vecs.push_back('{"max+max",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000});
    vecs.push_back('{"denorm+1",   32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000});
    vecs.push_back('{"nan_in",     32'h7FC12345, 32'h3F800000, 1'b0, FP_QNAN});
    vecs.push_back('{"-inf+1",     32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000});
    vecs.push_back('{"-0 sub +0",  32'h80000000, 32'h00000000, 1'b1, 32'h80000000});
    vecs.push_back('{"+0+-0",      32'h00000000, 32'h80000000, 1'b0, 32'h00000000});
    vecs.push_back('{"x+0",        32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB});
    vecs.push_back('{"underflow",  32'h00800000, 32'h00800001, 1'b1, 32'h80000000});
    vecs.push_back('{"2-1",        32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000});
    vecs.push_back('{"-1+-1",      32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000});
    vecs.push_back('{"round_ovf",  32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000});
    vecs.push_back('{"sticky_far", 32'h3F800000, 32'h2F800000, 1'b0, 32'h3F800000});
    vecs.push_back('{"1-tiny",     32'h3F800000, 32'h2F800000, 1'b1, 32'h3F800000});
    vecs.push_back('{"small+big",  32'h3F800000, 32'h40400000, 1'b0, 32'h40800000});
    vecs.push_back('{"inf sub inf",32'h7F800000, 32'h7F800000, 1'b1, FP_QNAN});

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0;
    out_ready = 1'b1; cur_exp = '0;

    // Reset state
    @(posedge clk); @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // First transaction and its latency
    drive(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    wait_drain(20);
    check("latency", last_lat, 32'd3);

    // Table of vectors, back-to-back
    foreach (vecs[i]) drive(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp);
    wait_drain(40);

    // Backpressure: 5-op stream, out_ready low for 4 cycles mid-stream
    base = n_out;
    fork
      begin
        for (int i = 0; i < 5; i++) drive(bp_a[i], 32'h3F800000, 1'b0, bp_e[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = result;
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        for (int k = 1; k < 4; k++) begin
          @(negedge clk);
          check($sformatf("stall_in_ready%0d", k), {31'b0, in_ready}, 32'd0);
          check($sformatf("stall_result%0d", k), result, held);
          check($sformatf("stall_valid%0d", k), {31'b0, out_valid}, 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain(60);
    check("bp_delivered", n_out - base, 32'd5);

    // Reset with two operations in flight
    drive(32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
    drive(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("flush_idle_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    base = n_out;
    drive(32'h40400000, 32'hBFC00000, 1'b0, 32'h3FC00000);
    wait_drain(20);
    check("post_rst_latency", last_lat, 32'd3);
    check("post_rst_count", n_out - base, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
